// File: rtl/e4m3_from_int_if.sv
// Valid/ready operand and result channels of the integer to E4M3 converter.
interface e4m3_from_int_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  y;

    modport master (output in_valid, a, out_ready, input in_ready, out_valid, y);
    modport slave  (input in_valid, a, out_ready, output in_ready, out_valid, y);
endinterface

// File: rtl/e4m3_from_int.sv
// Signed fixed-point to FP8 E4M3 converter: bit-serial normalise, RNE round,
// saturate to +-448.
module e4m3_from_int #(
    parameter int FRAC_BITS = 0
) (
    input  logic            clock,
    input  logic            reset,
    e4m3_from_int_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [16:0] mag_q, mag_d;
    logic [4:0]  s_q, s_d;
    logic [7:0]  y_q, y_d;

    logic [5:0]  exp_raw, exp_r;
    logic [2:0]  m, m_r;
    logic [3:0]  m_sum;
    logic        guard, sticky, rnd_up, sat;

    // Rounding datapath; only consumed in ROUND, where mag_q[16] is the hidden one.
    always_comb begin
        exp_raw = 6'(23 - FRAC_BITS) - {1'b0, s_q};
        m       = mag_q[15:13];
        guard   = mag_q[12];
        sticky  = |mag_q[11:0];
        rnd_up  = guard & (sticky | m[0]);
        m_sum   = {1'b0, m} + {3'b000, rnd_up};
        exp_r   = exp_raw + {5'b0, m_sum[3]};
        m_r     = m_sum[2:0];
        sat     = (exp_r > 6'd15) || ((exp_r == 6'd15) && (m_r == 3'b111));
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        s_d     = s_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d = bus.a[15];
                    mag_d  = bus.a[15] ? (17'd0 - {bus.a[15], bus.a}) : {1'b0, bus.a};
                    s_d    = 5'd0;
                    if (bus.a == 16'h0000) begin
                        y_d     = 8'h00;
                        state_d = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (mag_q[16]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[15:0], 1'b0};
                    s_d   = s_q + 5'd1;
                end
            end
            ROUND: begin
                y_d     = sat ? {sign_q, 7'h7E} : {sign_q, exp_r[3:0], m_r};
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            s_q     <= '0;
            y_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            s_q     <= s_d;
            y_q     <= y_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.y         = y_q;
endmodule

// File: tb/tb_e4m3_from_int.sv
// Scoreboard bench for e4m3_from_int with FRAC_BITS=0 and FRAC_BITS=4 instances.
module tb_e4m3_from_int;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_y;

    always #5 clock = ~clock;

    e4m3_from_int_if bus();
    e4m3_from_int_if bus4();

    e4m3_from_int #(.FRAC_BITS(0)) dut0 (.clock(clock), .reset(reset), .bus(bus));
    e4m3_from_int #(.FRAC_BITS(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4));

    // Expected edges from accept to out_valid: leading zeros of the 17-bit |a| plus 2.
    function automatic int exp_lat(input logic [15:0] v);
        logic [16:0] mg;
        int lz;
        mg = v[15] ? (17'd0 - {v[15], v}) : {1'b0, v};
        if (mg == 17'd0) return 0;
        lz = 0;
        while (!mg[16]) begin
            mg = mg << 1;
            lz++;
        end
        return lz + 2;
    endfunction

    task automatic send(input logic [15:0] v, output bit ok);
        ok = 1'b0;
        bus.a = v;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.in_ready) ok = 1'b1;
            @(posedge clock); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        while (!bus.out_valid && cnt < 40) begin
            @(posedge clock); #1;
            cnt++;
        end
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.y !== 8'h00) begin
            errors++;
            $display("FAIL reset0: in_ready=%b out_valid=%b y=%h, want 1 0 00", bus.in_ready, bus.out_valid, bus.y);
        end
        checks++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.y !== 8'h00) begin
            errors++;
            $display("FAIL reset4: in_ready=%b out_valid=%b y=%h, want 1 0 00", bus4.in_ready, bus4.out_valid, bus4.y);
        end
    endtask

    task automatic test_one_latency();
        bit ok;
        int cnt;
        bit busy_bad;
        exp_q.push_back(8'h38);
        send(16'h0001, ok);
        cnt = 0;
        busy_bad = 1'b0;
        while (ok && !bus.out_valid && cnt < 40) begin
            if (bus.in_ready !== 1'b0) busy_bad = 1'b1;
            @(posedge clock); #1;
            cnt++;
        end
        checks++;
        if (!ok || cnt != 18) begin
            errors++;
            $display("FAIL lat_one: accepted=%b edges=%0d, want 1 18", ok, cnt);
        end
        checks++;
        if (busy_bad || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_ready: in_ready high while busy, want 0");
        end
        exp_y = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.y !== exp_y) begin
            errors++;
            $display("FAIL y_one: out_valid=%b y=%h, want 1 %h", bus.out_valid, bus.y, exp_y);
        end
        ack();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.y !== exp_y) begin
            errors++;
            $display("FAIL ack_one: out_valid=%b in_ready=%b y=%h, want 0 1 %h", bus.out_valid, bus.in_ready, bus.y, exp_y);
        end
    endtask

    task automatic test_table();
        logic [15:0] av[16] = '{16'hFFFD, 16'd15, 16'd17, 16'd19, 16'd31, 16'd448, 16'd480, 16'd500,
                                16'h8000, 16'h0000, 16'd9, 16'hFFFF, 16'd127, 16'd100, 16'd18, 16'hFE0C};
        logic [7:0]  ev[16] = '{8'hC4, 8'h57, 8'h58, 8'h5A, 8'h60, 8'h7E, 8'h7E, 8'h7E,
                                8'hFE, 8'h00, 8'h51, 8'hB8, 8'h70, 8'h6C, 8'h59, 8'hFE};
        bit ok;
        int cnt;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(ev[i]);
            send(av[i], ok);
            wait_out(cnt);
            exp_y = exp_q.pop_front();
            checks++;
            if (!ok || bus.out_valid !== 1'b1 || cnt != exp_lat(av[i])) begin
                errors++;
                $display("FAIL lat a=%h: accepted=%b out_valid=%b edges=%0d, want 1 1 %0d", av[i], ok, bus.out_valid, cnt, exp_lat(av[i]));
            end
            checks++;
            if (bus.y !== exp_y) begin
                errors++;
                $display("FAIL conv a=%h: y=%h, want %h", av[i], bus.y, exp_y);
            end
            ack();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int cnt;
        bit bad;
        exp_q.push_back(8'h57);
        send(16'd15, ok);
        wait_out(cnt);
        exp_y = exp_q.pop_front();
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.y !== exp_y || bus.in_ready !== 1'b0) bad = 1'b1;
            @(posedge clock); #1;
        end
        checks++;
        if (!ok || bad || bus.out_valid !== 1'b1 || bus.y !== exp_y) begin
            errors++;
            $display("FAIL hold: out_valid=%b y=%h unstable=%b, want 1 %h 0", bus.out_valid, bus.y, bad, exp_y);
        end
        ack();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cnt;
        exp_q.push_back(8'h38);
        send(16'h0001, ok);
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        checks++;
        if (!ok || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.y !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b y=%h, want 0 1 00", bus.out_valid, bus.in_ready, bus.y);
        end
        exp_q.push_back(8'h40);
        send(16'd2, ok);
        wait_out(cnt);
        exp_y = exp_q.pop_front();
        checks++;
        if (!ok || bus.out_valid !== 1'b1 || bus.y !== exp_y || cnt != 17) begin
            errors++;
            $display("FAIL after_reset: out_valid=%b y=%h edges=%0d, want 1 %h 17", bus.out_valid, bus.y, cnt, exp_y);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        logic [15:0] av[4] = '{16'd0, 16'd19, 16'hFFF1, 16'd0};
        logic [7:0]  ev[4] = '{8'h00, 8'h5A, 8'hD7, 8'h00};
        bit ok;
        int cnt;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ev[i]);
            send(av[i], ok);
            wait_out(cnt);
            exp_y = exp_q.pop_front();
            checks++;
            if (!ok || bus.out_valid !== 1'b1 || bus.y !== exp_y || cnt != exp_lat(av[i])) begin
                errors++;
                $display("FAIL b2b a=%h: out_valid=%b y=%h edges=%0d, want 1 %h %0d", av[i], bus.out_valid, bus.y, cnt, exp_y, exp_lat(av[i]));
            end
            @(posedge clock); #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_release a=%h: out_valid=%b in_ready=%b, want 0 1", av[i], bus.out_valid, bus.in_ready);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_frac4();
        logic [15:0] av[3] = '{16'h0008, 16'h0001, 16'hFFF0};
        logic [7:0]  ev[3] = '{8'h30, 8'h18, 8'hB8};
        bit ok;
        int cnt;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ev[i]);
            ok = 1'b0;
            bus4.a = av[i];
            bus4.in_valid = 1'b1;
            for (int k = 0; k < 50 && !ok; k++) begin
                if (bus4.in_ready) ok = 1'b1;
                @(posedge clock); #1;
            end
            bus4.in_valid = 1'b0;
            cnt = 0;
            while (!bus4.out_valid && cnt < 40) begin
                @(posedge clock); #1;
                cnt++;
            end
            exp_y = exp_q.pop_front();
            checks++;
            if (!ok || bus4.out_valid !== 1'b1 || bus4.y !== exp_y || cnt != exp_lat(av[i])) begin
                errors++;
                $display("FAIL frac4 a=%h: out_valid=%b y=%h edges=%0d, want 1 %h %0d", av[i], bus4.out_valid, bus4.y, cnt, exp_y, exp_lat(av[i]));
            end
            bus4.out_ready = 1'b1;
            @(posedge clock); #1;
            bus4.out_ready = 1'b0;
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.a          = 16'h0000;
        bus.out_ready  = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.a         = 16'h0000;
        bus4.out_ready = 1'b0;
        test_reset();
        test_one_latency();
        test_table();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_frac4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
